// File: rtl/count_sample_fifo.sv
// Samples a free-running counter on demand, flags any break in the expected step,
// and queues {err, sample} in a small FIFO drained through a valid/ready port.
module count_sample_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned STEP  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_en,
    input  logic [WIDTH-1:0]             counter_value,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_step_err,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   overflow_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH:0]       mem_q [DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        rptr_q, rptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [7:0]           ovf_q, ovf_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 has_prev_q, has_prev_d;

    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 step_err;
    logic [WIDTH-1:0]     expected;

    always_comb begin
        full      = (level_q == FULL_LEVEL);
        out_valid = (level_q != '0);
        pop       = out_valid && out_ready;
        // A full FIFO can still accept a sample when the head leaves in the same cycle.
        push      = sample_en && (!full || pop);
        drop      = sample_en && full && !pop;
        expected  = prev_q + STEP_W;
        step_err  = has_prev_q && (counter_value != expected);

        out_data     = out_valid ? mem_q[rptr_q][WIDTH-1:0] : '0;
        out_step_err = out_valid ? mem_q[rptr_q][WIDTH]     : 1'b0;
        level        = level_q;
        overflow_cnt = ovf_q;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;

        // Track the counter stream itself, so dropped samples still advance prev.
        if (sample_en) begin
            prev_d     = counter_value;
            has_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ovf_q      <= '0;
            prev_q     <= '0;
            has_prev_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
        end
    end

    // Storage needs no reset: the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {step_err, counter_value};
    end

endmodule

// File: tb/tb_count_sample_fifo.sv
// Directed bench for count_sample_fifo: reset, ordering, wrap/step errors,
// overflow, full push+pop, counter saturation and mid-stream reset.
module tb_count_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [15:0] counter_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_step_err;
    logic [2:0]  level;
    logic [7:0]  overflow_cnt;

    int vectors = 0;
    int miscompares = 0;

    count_sample_fifo #(.WIDTH(16), .DEPTH(4), .STEP(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .counter_value(counter_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_step_err (out_step_err),
        .level        (level),
        .overflow_cnt (overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [15:0] data, input logic err);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " data"}, 32'(out_data), 32'(data));
        check({tag, " err"}, 32'(out_step_err), 32'(err));
    endtask

    task automatic check_empty(input string tag);
        check({tag, " valid"}, 32'(out_valid), 32'd0);
        check({tag, " data"}, 32'(out_data), 32'd0);
        check({tag, " err"}, 32'(out_step_err), 32'd0);
        check({tag, " level"}, 32'(level), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [15:0] wrap_vals [5] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0002, 16'h0003};
    logic        wrap_errs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset state and asynchronous mid-cycle reset
        tick();
        check_empty("por");
        check("por ovf", 32'(overflow_cnt), 32'd0);
        rst_n = 1'b1;
        sample_en = 1'b1;
        counter_value = 16'h1234;
        tick();
        sample_en = 1'b0;
        check_head("pre-reset", 16'h1234, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_empty("async reset");
        check("async reset ovf", 32'(overflow_cnt), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_empty("ready while empty");

        // In-order stream, one pop per cycle
        for (int i = 0; i < 10; i++) begin
            sample_en = 1'b1;
            counter_value = 16'hA5B6 + 16'(i);
            tick();
            check_head("stream", 16'hA5B6 + 16'(i), 1'b0);
            check("stream level", 32'(level), 32'd1);
        end
        sample_en = 1'b0;
        tick();
        check_empty("stream drained");

        // Wrap and step errors from a fresh start
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            sample_en = 1'b1;
            counter_value = wrap_vals[i];
            tick();
            check_head("wrap", wrap_vals[i], wrap_errs[i]);
        end
        sample_en = 1'b0;
        tick();
        check_empty("wrap drained");

        // Overflow: prev=0x0003 so 0x0010 errs, 0x0014/0x0015 are dropped
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_en = 1'b1;
            counter_value = 16'h0010 + 16'(i);
            tick();
        end
        sample_en = 1'b0;
        check("ovf level", 32'(level), 32'd4);
        check("ovf count", 32'(overflow_cnt), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head("drain", 16'h0010 + 16'(i), (i == 0));
            tick();
        end
        check_empty("ovf drained");
        out_ready = 1'b0;
        sample_en = 1'b1;
        counter_value = 16'h0016;
        tick();
        check_head("after drop", 16'h0016, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            counter_value = 16'h0017 + 16'(i);
            tick();
        end
        check("fill level", 32'(level), 32'd4);
        counter_value = 16'h001A;
        out_ready = 1'b1;
        tick();
        sample_en = 1'b0;
        check("pp level", 32'(level), 32'd4);
        check("pp ovf", 32'(overflow_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check_head("pp drain", 16'h0017 + 16'(i), 1'b0);
            tick();
        end
        check_empty("pp drained");

        // Saturation then mid-stream reset
        out_ready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 304; i++) begin
            counter_value = 16'h001B + 16'(i);
            tick();
        end
        sample_en = 1'b0;
        check("sat ovf", 32'(overflow_cnt), 32'd255);
        check("sat level", 32'(level), 32'd4);
        pulse_reset();
        check("rst ovf", 32'(overflow_cnt), 32'd0);
        check_empty("rst mid-stream");
        sample_en = 1'b1;
        counter_value = 16'h5555;
        tick();
        sample_en = 1'b0;
        check_head("first after rst", 16'h5555, 1'b0);
        check("first after rst level", 32'(level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
